// File: rtl/led_pkg.sv
// Shared encodings for the multi-mode LED controller: output modes and
// register addresses as seen from the MemOrIO LED decode.
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_STATIC = 2'd0,
    LED_MODE_BLINK  = 2'd1,
    LED_MODE_ROTATE = 2'd2,
    LED_MODE_PWM    = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    LED_ADDR_DATA   = 2'd0,
    LED_ADDR_MODE   = 2'd1,
    LED_ADDR_BRIGHT = 2'd2,
    LED_ADDR_RELOAD = 2'd3
  } led_addr_e;

endpackage

// File: rtl/led_tick_gen.sv
// Programmable tick prescaler. Counts down from the reload value and emits
// a one-cycle tick when the count is zero, reloading in that same cycle.
// A load strobe restarts the count immediately and swallows any tick due
// in that cycle.
module led_tick_gen #(
  parameter int PRESC_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PRESC_W-1:0] reload_i,
  input  logic               load_i,
  output logic               tick_o
);

  localparam logic [PRESC_W-1:0] CNT_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // Next count and tick: load beats expiry, expiry reloads, else count down.
  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = reload_i;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = reload_i;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-mode board LED driver: a four-register file (DATA, MODE, BRIGHT,
// RELOAD) written from MemOrIO, driving WIDTH registered LED outputs in
// static, blink, rotate (marquee) or PWM-dimmed mode. Blink and rotate
// advance on ticks from a shared prescaler; PWM runs every cycle.
module led_ctrl_multi
  import led_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PWM_BITS = 4,
  parameter int PRESC_W  = 24
) (
  input  logic             led_clk,
  input  logic             ledrst,
  input  logic             ledwrite,
  input  logic [1:0]       ledaddr,
  input  logic [31:0]      ledwdata,
  output logic [31:0]      ledrdata,
  output logic [WIDTH-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  // Marquee step: shift left by one, MSB wraps around into the LSB.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return (v << 1) | (v >> (WIDTH - 1));
  endfunction

  logic [WIDTH-1:0]    data_q,    data_d;
  led_mode_e           mode_q,    mode_d;
  logic [PWM_BITS-1:0] bright_q,  bright_d;
  logic [PRESC_W-1:0]  reload_q,  reload_d;
  logic                phase_q,   phase_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [PWM_BITS-1:0] pwm_q,     pwm_d;
  logic [WIDTH-1:0]    led_q,     led_d;

  logic wr_data;
  logic wr_mode;
  logic wr_bright;
  logic wr_reload;
  logic tick;
  logic presc_load;
  logic unused_wdata;

  assign wr_data   = ledwrite && (ledaddr == LED_ADDR_DATA);
  assign wr_mode   = ledwrite && (ledaddr == LED_ADDR_MODE);
  assign wr_bright = ledwrite && (ledaddr == LED_ADDR_BRIGHT);
  assign wr_reload = ledwrite && (ledaddr == LED_ADDR_RELOAD);

  // Changing the period or the mode restarts the prescaler so the new
  // setting takes effect from a clean count.
  assign presc_load = wr_mode || wr_reload;

  // Upper write-data bits beyond each register's width are don't-care.
  assign unused_wdata = ^ledwdata;

  led_tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick (
    .clk_i    (led_clk),
    .rst_i    (ledrst),
    .reload_i (reload_d),
    .load_i   (presc_load),
    .tick_o   (tick)
  );

  // Register file updates plus blink/rotate/PWM state advance; register
  // writes are applied after the tick so a write always wins.
  always_comb begin
    data_d    = data_q;
    mode_d    = mode_q;
    bright_d  = bright_q;
    reload_d  = reload_q;
    phase_d   = phase_q;
    pattern_d = pattern_q;
    pwm_d     = pwm_q + PWM_ONE;

    if (tick) begin
      if (mode_q == LED_MODE_BLINK) begin
        phase_d = ~phase_q;
      end
      if (mode_q == LED_MODE_ROTATE) begin
        pattern_d = rotl1(pattern_q);
      end
    end

    if (wr_data) begin
      data_d    = ledwdata[WIDTH-1:0];
      pattern_d = ledwdata[WIDTH-1:0];
    end
    if (wr_mode) begin
      mode_d    = led_mode_e'(ledwdata[1:0]);
      phase_d   = 1'b1;
      pattern_d = data_q;
    end
    if (wr_bright) begin
      bright_d = ledwdata[PWM_BITS-1:0];
    end
    if (wr_reload) begin
      reload_d = ledwdata[PRESC_W-1:0];
    end
  end

  // LED drive is computed from registered state, giving one edge of
  // latency after the register write edge.
  always_comb begin
    led_d = '0;
    case (mode_q)
      LED_MODE_STATIC: led_d = data_q;
      LED_MODE_BLINK:  led_d = phase_q ? data_q : '0;
      LED_MODE_ROTATE: led_d = pattern_q;
      LED_MODE_PWM:    led_d = (pwm_q < bright_q) ? data_q : '0;
      default:         led_d = '0;
    endcase
  end

  // State registers; reset returns everything to a dark, static setup.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      data_q    <= '0;
      mode_q    <= LED_MODE_STATIC;
      bright_q  <= '0;
      reload_q  <= '0;
      phase_q   <= 1'b1;
      pattern_q <= '0;
      pwm_q     <= '0;
      led_q     <= '0;
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      bright_q  <= bright_d;
      reload_q  <= reload_d;
      phase_q   <= phase_d;
      pattern_q <= pattern_d;
      pwm_q     <= pwm_d;
      led_q     <= led_d;
    end
  end

  // Zero-extended readback of the addressed register.
  always_comb begin
    ledrdata = '0;
    case (ledaddr)
      LED_ADDR_DATA:   ledrdata[WIDTH-1:0]    = data_q;
      LED_ADDR_MODE:   ledrdata[1:0]          = mode_q;
      LED_ADDR_BRIGHT: ledrdata[PWM_BITS-1:0] = bright_q;
      LED_ADDR_RELOAD: ledrdata[PRESC_W-1:0]  = reload_q;
      default:         ledrdata               = '0;
    endcase
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Scoreboard bench for led_ctrl_multi: stimulus queues hand-derived
// expectations tagged with the cycle they apply to; a monitor samples
// led_out / ledrdata on each falling edge and compares.
module tb_led_ctrl_multi;
  import led_pkg::*;

  localparam int W = 16;

  logic          led_clk;
  logic          ledrst;
  logic          ledwrite;
  logic [1:0]    ledaddr;
  logic [31:0]   ledwdata;
  logic [31:0]   ledrdata;
  logic [W-1:0]  led_out;

  led_ctrl_multi #(
    .WIDTH    (W),
    .PWM_BITS (4),
    .PRESC_W  (24)
  ) dut (
    .led_clk  (led_clk),
    .ledrst   (ledrst),
    .ledwrite (ledwrite),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .ledrdata (ledrdata),
    .led_out  (led_out)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  int cyc = 0;
  always @(posedge led_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rel_cyc = 0;

  function automatic void push(input int c, input bit rd, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c;
    e.rd  = rd;
    e.v   = v;
    e.nm  = nm;
    sbq.push_back(e);
  endfunction

  // PWM counter starts at 0 on release and steps every edge; the LED at
  // edge e reflects the counter value left by edge e-1.
  function automatic logic [31:0] pwm_exp(input int e, input int b);
    return (((e - 1 - rel_cyc) % 16) < b) ? 32'h0000_FFFF : 32'h0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge led_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ledwrite = 1'b1;
    ledaddr  = a;
    ledwdata = d;
    wait_cyc(1);
    ledwrite = 1'b0;
  endtask

  // Monitor
  exp_t        m_e;
  logic [31:0] m_act;
  initial begin
    forever begin
      @(negedge led_clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        m_e   = sbq.pop_front();
        m_act = m_e.rd ? ledrdata : 32'(led_out);
        n_cmp++;
        if (m_e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s: sample missed, due cycle %0d, now %0d", m_e.nm, m_e.cyc, cyc);
        end else if (m_act !== m_e.v) begin
          n_bad++;
          $display("FAIL %s: got %h, wanted %h (cycle %0d)", m_e.nm, m_act, m_e.v, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [31:0] rb_exp [4];
  logic [15:0] rot_exp [8];

  initial begin
    rb_exp  = '{32'h0000_FFFF, 32'h0000_0003, 32'h0000_000F, 32'h00FF_FFFF};
    rot_exp = '{16'h8001, 16'h0003, 16'h0006, 16'h000C,
                16'h0018, 16'h0010, 16'h0020, 16'h0040};
    ledrst   = 1'b1;
    ledwrite = 1'b0;
    ledaddr  = 2'd0;
    ledwdata = 32'h0;

    // Reset state
    wait_cyc(3);
    push(cyc, 1'b0, 32'h0, "rst_led");
    for (int a = 0; a < 4; a++) begin
      ledaddr = 2'(a);
      push(cyc, 1'b1, 32'h0, $sformatf("rst_rd%0d", a));
      wait_cyc(1);
    end
    ledrst  = 1'b0;
    rel_cyc = cyc;
    ledaddr = 2'd0;
    for (int k = 1; k <= 3; k++) push(cyc + k, 1'b0, 32'h0, "post_rst_led");
    wait_cyc(3);

    // Static hold with write strobe idle
    wr(LED_ADDR_DATA, 32'h0000_A5A5);
    push(cyc, 1'b0, 32'h0, "static_latency");
    for (int k = 1; k <= 100; k++) push(cyc + k, 1'b0, 32'h0000_A5A5, $sformatf("static[%0d]", k));
    wait_cyc(100);

    // Blink, 4-cycle half period
    wr(LED_ADDR_DATA, 32'h0000_00FF);
    wr(LED_ADDR_RELOAD, 32'h3);
    wr(LED_ADDR_MODE, 32'(LED_MODE_BLINK));
    for (int k = 1; k <= 16; k++)
      push(cyc + k, 1'b0, ((((k - 1) / 4) % 2) == 0) ? 32'h0000_00FF : 32'h0, $sformatf("blink[%0d]", k));
    wait_cyc(17);

    // Asynchronous reset while blink output is lit
    ledrst = 1'b1;
    push(cyc, 1'b0, 32'h0, "rst_async_led");
    for (int a = 0; a < 4; a++) begin
      ledaddr = 2'(a);
      push(cyc, 1'b1, 32'h0, $sformatf("rst_mid_rd%0d", a));
      wait_cyc(1);
    end
    ledrst  = 1'b0;
    rel_cyc = cyc;
    ledaddr = 2'd0;
    for (int k = 1; k <= 3; k++) push(cyc + k, 1'b0, 32'h0, "post_rst2_led");
    wait_cyc(3);

    // Rotate every cycle, DATA write colliding with a tick
    wr(LED_ADDR_DATA, 32'h0000_8001);
    wr(LED_ADDR_RELOAD, 32'h0);
    wr(LED_ADDR_MODE, 32'(LED_MODE_ROTATE));
    for (int k = 1; k <= 8; k++) push(cyc + k, 1'b0, 32'(rot_exp[k-1]), $sformatf("rotate[%0d]", k));
    wait_cyc(4);
    wr(LED_ADDR_DATA, 32'h0000_0010);
    wait_cyc(3);

    // PWM at BRIGHT 4, 0 and 15
    wr(LED_ADDR_DATA, 32'h0000_FFFF);
    wr(LED_ADDR_BRIGHT, 32'h4);
    wr(LED_ADDR_MODE, 32'(LED_MODE_PWM));
    for (int k = 1; k <= 32; k++) push(cyc + k, 1'b0, pwm_exp(cyc + k, 4), $sformatf("pwm4[%0d]", k));
    wait_cyc(32);
    wr(LED_ADDR_BRIGHT, 32'h0);
    for (int k = 1; k <= 16; k++) push(cyc + k, 1'b0, 32'h0, $sformatf("pwm0[%0d]", k));
    wait_cyc(16);
    wr(LED_ADDR_BRIGHT, 32'hF);
    for (int k = 1; k <= 16; k++) push(cyc + k, 1'b0, pwm_exp(cyc + k, 15), $sformatf("pwm15[%0d]", k));
    wait_cyc(16);

    // Readback width truncation
    for (int a = 0; a < 4; a++) begin
      wr(2'(a), 32'hFFFF_FFFF);
      push(cyc, 1'b1, rb_exp[a], $sformatf("readback%0d", a));
      wait_cyc(1);
    end

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge led_clk);
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d left, wanted 0", sbq.size());
      n_cmp += sbq.size();
      n_bad += sbq.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
